// File: rtl/mem_stage.sv
// Memory stage: EX/MEM pipeline register plus a single-outstanding load/store
// handshake that stalls upstream while an access is in flight.
module mem_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        regwrite_i,
  input  logic        memtoreg_i,
  input  logic        memread_i,
  input  logic        memwrite_i,
  input  logic [15:0] memdata_i,
  input  logic [15:0] aluresult_i,
  input  logic [3:0]  regdst_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [15:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic [15:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        stall_o,
  output logic        regwrite_o,
  output logic [3:0]  regdst_o,
  output logic [15:0] wbdata_o,
  output logic        err_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_regwrite;
  logic        r_memtoreg;
  logic        r_memwrite;
  logic [15:0] r_memdata;
  logic [15:0] r_aluresult;
  logic [3:0]  r_regdst;
  logic [15:0] r_rdata;
  logic [15:0] r_cnt;
  logic        r_err;

  logic        w_capture;
  logic        w_timeout;

  assign w_capture = (r_state != S_BUSY);
  assign w_timeout = (r_cnt == 16'(TIMEOUT - 1));

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: w_state_nxt = (memread_i || memwrite_i) ? S_BUSY : S_IDLE;
      S_BUSY:         if (mem_ack_i || w_timeout) w_state_nxt = S_DONE;
      default:        w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_regwrite  <= 1'b0;
      r_memtoreg  <= 1'b0;
      r_memwrite  <= 1'b0;
      r_memdata   <= '0;
      r_aluresult <= '0;
      r_regdst    <= '0;
    end else if (w_capture) begin
      r_regwrite  <= regwrite_i;
      r_memtoreg  <= memtoreg_i;
      r_memwrite  <= memwrite_i;
      r_memdata   <= memdata_i;
      r_aluresult <= aluresult_i;
      r_regdst    <= regdst_i;
    end
  end

  // Counter is zeroed on every capture edge, which covers each entry to BUSY.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                r_cnt <= '0;
    else if (w_capture)     r_cnt <= '0;
    else if (r_cnt != '1)   r_cnt <= r_cnt + 16'd1;
  end

  // Ack takes priority over timeout on the same edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_BUSY) begin
      if (mem_ack_i) begin
        r_rdata <= mem_rdata_i;
        r_err   <= 1'b0;
      end else if (w_timeout) begin
        r_rdata <= '1;
        r_err   <= 1'b1;
      end
    end else begin
      r_err <= 1'b0;
    end
  end

  assign mem_req_o   = (r_state == S_BUSY);
  assign stall_o     = (r_state == S_BUSY);
  assign mem_we_o    = r_memwrite;
  assign mem_addr_o  = r_aluresult;
  assign mem_wdata_o = r_memdata;
  assign regdst_o    = r_regdst;
  assign wbdata_o    = r_memtoreg ? r_rdata : r_aluresult;
  assign err_o       = (r_state == S_DONE) && r_err;
  assign regwrite_o  = r_regwrite && (r_state != S_BUSY) &&
                       !((r_state == S_DONE) && r_err);

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage (TIMEOUT = 4), plus an
// asynchronous reset-during-BUSY sequence.
module tb_mem_stage;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        regwrite_i = 1'b0, memtoreg_i = 1'b0, memread_i = 1'b0, memwrite_i = 1'b0;
  logic [15:0] memdata_i = '0, aluresult_i = '0, mem_rdata_i = '0;
  logic [3:0]  regdst_i = '0;
  logic        mem_ack_i = 1'b0;
  logic        mem_req_o, mem_we_o, stall_o, regwrite_o, err_o;
  logic [15:0] mem_addr_o, mem_wdata_o, wbdata_o;
  logic [3:0]  regdst_o;

  int checks = 0;
  int failures = 0;

  mem_stage #(.TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .regwrite_i(regwrite_i), .memtoreg_i(memtoreg_i),
    .memread_i(memread_i), .memwrite_i(memwrite_i),
    .memdata_i(memdata_i), .aluresult_i(aluresult_i), .regdst_i(regdst_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .stall_o(stall_o), .regwrite_o(regwrite_o), .regdst_o(regdst_o),
    .wbdata_o(wbdata_o), .err_o(err_o)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rw, mtr, mrd, mwr;
    logic [15:0] md, alu;
    logic [3:0]  rd;
    logic        ack;
    logic [15:0] rdata;
    logic        e_req, e_we;
    logic [15:0] e_addr, e_wd;
    logic        e_stall, e_rw;
    logic [3:0]  e_rd;
    logic [15:0] e_wb;
    logic        e_err;
  } vec_t;

  localparam int NV = 28;
  vec_t tv [NV];

  function automatic vec_t mk(
    input logic rw, mtr, mrd, mwr, input logic [15:0] md, alu, input logic [3:0] rd,
    input logic ack, input logic [15:0] rdata,
    input logic e_req, e_we, input logic [15:0] e_addr, e_wd,
    input logic e_stall, e_rw, input logic [3:0] e_rd, input logic [15:0] e_wb,
    input logic e_err);
    vec_t v;
    v.rw = rw; v.mtr = mtr; v.mrd = mrd; v.mwr = mwr; v.md = md; v.alu = alu;
    v.rd = rd; v.ack = ack; v.rdata = rdata;
    v.e_req = e_req; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
    v.e_stall = e_stall; v.e_rw = e_rw; v.e_rd = e_rd; v.e_wb = e_wb; v.e_err = e_err;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    regwrite_i = v.rw; memtoreg_i = v.mtr; memread_i = v.mrd; memwrite_i = v.mwr;
    memdata_i = v.md; aluresult_i = v.alu; regdst_i = v.rd;
    mem_ack_i = v.ack; mem_rdata_i = v.rdata;
  endtask

  task automatic chk_all(input int row, input vec_t v);
    chk("mem_req",   row, 16'(mem_req_o),  16'(v.e_req));
    chk("mem_we",    row, 16'(mem_we_o),   16'(v.e_we));
    chk("mem_addr",  row, mem_addr_o,      v.e_addr);
    chk("mem_wdata", row, mem_wdata_o,     v.e_wd);
    chk("stall",     row, 16'(stall_o),    16'(v.e_stall));
    chk("regwrite",  row, 16'(regwrite_o), 16'(v.e_rw));
    chk("regdst",    row, 16'(regdst_o),   16'(v.e_rd));
    chk("wbdata",    row, wbdata_o,        v.e_wb);
    chk("err",       row, 16'(err_o),      16'(v.e_err));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t nop, v;
    nop = mk(0,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0);

    // ALU stream
    tv[0]  = mk(1,0,0,0,0,16'h0011,1,0,0,        0,0,16'h0011,0,0,1,1,16'h0011,0);
    tv[1]  = mk(1,0,0,0,0,16'h0022,2,0,0,        0,0,16'h0022,0,0,1,2,16'h0022,0);
    tv[2]  = mk(1,0,0,0,0,16'h0033,3,0,0,        0,0,16'h0033,0,0,1,3,16'h0033,0);
    // load, ack on third BUSY edge; next instruction held while stalled
    tv[3]  = mk(1,1,1,0,0,16'h0100,5,0,0,        1,0,16'h0100,0,1,0,5,16'h0000,0);
    tv[4]  = mk(1,0,0,0,0,16'h0077,7,0,0,        1,0,16'h0100,0,1,0,5,16'h0000,0);
    tv[5]  = mk(1,0,0,0,0,16'h0077,7,0,0,        1,0,16'h0100,0,1,0,5,16'h0000,0);
    tv[6]  = mk(1,0,0,0,0,16'h0077,7,1,16'hBEEF, 0,0,16'h0100,0,0,1,5,16'hBEEF,0);
    tv[7]  = mk(1,0,0,0,0,16'h0077,7,0,0,        0,0,16'h0077,0,0,1,7,16'h0077,0);
    // store then load, each acked on first BUSY edge; ack in DONE ignored
    tv[8]  = mk(0,0,0,1,16'h1234,16'h0200,0,0,0, 1,1,16'h0200,16'h1234,1,0,0,16'h0200,0);
    tv[9]  = mk(1,1,1,0,0,16'h0200,6,1,16'h0000, 0,1,16'h0200,16'h1234,0,0,0,16'h0200,0);
    tv[10] = mk(1,1,1,0,0,16'h0200,6,1,16'hDEAD, 1,0,16'h0200,0,1,0,6,16'h0000,0);
    tv[11] = mk(0,0,0,0,0,0,0,1,16'h1234,        0,0,16'h0200,0,0,1,6,16'h1234,0);
    tv[12] = nop;
    // timeout after 4 BUSY cycles
    tv[13] = mk(1,1,1,0,0,16'h0300,9,0,0,        1,0,16'h0300,0,1,0,9,16'h1234,0);
    tv[14] = mk(1,0,0,0,0,16'h00AA,4'hA,0,0,     1,0,16'h0300,0,1,0,9,16'h1234,0);
    tv[15] = tv[14];
    tv[16] = tv[14];
    tv[17] = mk(1,0,0,0,0,16'h00AA,4'hA,0,0,     0,0,16'h0300,0,0,0,9,16'hFFFF,1);
    tv[18] = mk(1,0,0,0,0,16'h00AA,4'hA,0,0,     0,0,16'h00AA,0,0,1,4'hA,16'h00AA,0);
    // ack coincides with last timeout cycle
    tv[19] = mk(1,1,1,0,0,16'h0400,4'hC,0,0,     1,0,16'h0400,0,1,0,4'hC,16'hFFFF,0);
    tv[20] = mk(0,0,0,0,0,0,0,0,0,               1,0,16'h0400,0,1,0,4'hC,16'hFFFF,0);
    tv[21] = tv[20];
    tv[22] = tv[20];
    tv[23] = mk(0,0,0,0,0,0,0,1,16'hCAFE,        0,0,16'h0400,0,0,1,4'hC,16'hCAFE,0);
    tv[24] = nop;
    // read and write together behaves as a store
    tv[25] = mk(0,0,1,1,16'h5555,16'h0500,0,0,0, 1,1,16'h0500,16'h5555,1,0,0,16'h0500,0);
    tv[26] = mk(0,0,0,0,0,0,0,1,0,               0,1,16'h0500,16'h5555,0,0,0,16'h0500,0);
    tv[27] = nop;

    // reset state
    repeat (2) @(posedge CLK);
    #1;
    chk_all(-1, nop);
    RST = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(tv[i]);
      @(posedge CLK);
      #1;
      chk_all(i, tv[i]);
    end

    // asynchronous reset in the second BUSY cycle of a load
    v = mk(1,0,1,0,0,16'h0040,4'h3,0,0, 0,0,0,0,0,0,0,0,0);
    drive(v);
    @(posedge CLK); #1;
    drive(nop);
    chk("rst_seq_req1", 100, 16'(mem_req_o), 16'd1);
    @(posedge CLK); #1;
    chk("rst_seq_stall2", 101, 16'(stall_o), 16'd1);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_async_req",   102, 16'(mem_req_o),  16'd0);
    chk("rst_async_stall", 102, 16'(stall_o),    16'd0);
    chk("rst_async_rw",    102, 16'(regwrite_o), 16'd0);
    chk("rst_async_addr",  102, mem_addr_o,      16'h0000);
    @(negedge CLK);
    RST = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(posedge CLK); #1;
      chk_all(103 + k, nop);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the 16-bit pipeline, directly downstream of the ID/EX register and the EX ALU. It holds the EX/MEM pipeline register and runs a single-outstanding load/store handshake to data memory. While an access is in flight it freezes everything upstream. It presents write-back data, destination register and write enable to the WB stage.

## Interface
Parameters:
- TIMEOUT, 255: maximum cycles spent in BUSY before the access is abandoned; 1..65535.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- regwrite_i  in  1  register write enable from EX.
- memtoreg_i  in  1  write-back selects memory data.
- memread_i  in  1  load request.
- memwrite_i  in  1  store request.
- memdata_i  in  16  store data.
- aluresult_i  in  16  ALU result; this is the address for loads and stores.
- regdst_i  in  4  destination register.
- mem_req_o  out  1  memory request, level-held through BUSY.
- mem_we_o  out  1  1 = store, 0 = load; valid while mem_req_o is 1.
- mem_addr_o  out  16  access address.
- mem_wdata_o  out  16  store data.
- mem_rdata_i  in  16  load data; sampled on the edge where mem_ack_i is 1.
- mem_ack_i  in  1  access complete.
- stall_o  out  1  freeze upstream stages and the PC.
- regwrite_o  out  1  WB write enable.
- regdst_o  out  4  WB destination register.
- wbdata_o  out  16  WB data.
- err_o  out  1  one-cycle pulse on timeout.

## Operation
- EX/MEM register: captures all `*_i` on every rising edge where stall_o is 0. It holds while stall_o is 1.
- State machine has three states: IDLE, BUSY and DONE.
  - IDLE or DONE, capture edge: go to BUSY if memread_i or memwrite_i is 1. Otherwise go to IDLE.
  - BUSY with mem_ack_i = 1: go to DONE and latch mem_rdata_i into rdata_q.
  - BUSY with the timeout counter equal to TIMEOUT - 1 and no ack: go to DONE, set err flag, and load rdata_q with 16'hFFFF.
- memread_i and memwrite_i both set: treat as a store (mem_we_o = 1).
- mem_req_o = (state == BUSY), registered.
- mem_we_o = latched memwrite.
- mem_addr_o = latched aluresult.
- mem_wdata_o = latched memdata.
- All mem_* outputs stay constant for the whole BUSY period.
- stall_o = (state == BUSY).
- wbdata_o = latched memtoreg ? rdata_q : latched aluresult.
- regdst_o = latched regdst.
- regwrite_o = latched regwrite, forced to 0 in BUSY and forced to 0 in a DONE reached by timeout.
- err_o = 1 only during the DONE cycle that follows a timeout.
- Timeout counter: 16 bits, cleared on entry to BUSY, increments each BUSY cycle, saturates and does not wrap.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-BUSY): state IDLE, all latched fields 0, rdata_q 0, counter 0, err 0.
  - Resulting outputs: mem_req_o 0, stall_o 0, regwrite_o 0, wbdata_o 0, regdst_o 0, err_o 0.
  - An aborted access is not retried.
- Non-memory instruction captured at edge N: regwrite_o, regdst_o and wbdata_o are valid during cycle N+1. Throughput is one per cycle.
- Memory instruction captured at edge N:
  - mem_req_o and stall_o rise in cycle N+1.
  - The earliest ack is sampled at edge N+1; DONE is then in cycle N+2, and the stall lasts 1 cycle.
  - With an ack sampled at edge N+k, the stall lasts k cycles and the WB outputs are valid in cycle N+k+1.
- An ack outside BUSY is ignored.
- An ack on the same edge as the timeout wins: normal completion, no err.
- DONE lasts exactly one cycle, because stall_o is 0 in DONE and the next instruction is captured at its closing edge.
- Back-to-back memory ops go DONE -> BUSY with no IDLE gap. mem_req_o drops for exactly the DONE cycle between them.
- Timeout: TIMEOUT cycles in BUSY, then DONE with err_o = 1 and regwrite_o = 0.

## Test plan
- Reset during BUSY:
  - Stimulus: load to 16'h0040; assert RST in the second BUSY cycle.
  - Required response: mem_req_o, stall_o and regwrite_o drop at once without waiting for an edge; after release, state is IDLE and all outputs are 0.
- ALU stream:
  - Stimulus: three non-memory instructions, regdst 1/2/3 with aluresult 16'h0011/0022/0033.
  - Required response: WB outputs present each value in the cycle after capture; stall_o is never 1.
- Load with 3-cycle ack delay:
  - Stimulus: load of addr 16'h0100, memtoreg = 1, regdst = 5; mem_ack_i returns 16'hBEEF on the third BUSY edge.
  - Required response: stall_o is high for 3 cycles with mem_we_o 0 and addr 16'h0100 held; next cycle shows regwrite_o 1, regdst_o 5, wbdata_o 16'hBEEF.
- Store followed by load, each acked on its first BUSY cycle:
  - Stimulus: store of 16'h1234 to 16'h0200, then a load from 16'h0200.
  - Required response: mem_req_o pattern is 1,0,1; mem_we_o is 1 then 0; store regwrite_o stays 0.
- Timeout with TIMEOUT = 4:
  - Stimulus: a load that is never acked.
  - Required response: stall_o is high for exactly 4 cycles, then err_o pulses 1 for one cycle with regwrite_o 0; the following instruction proceeds normally.
- Simultaneous events:
  - Stimulus: ack arrives on the same edge the counter reaches TIMEOUT - 1.
  - Required response: err_o stays 0 and wbdata_o equals mem_rdata_i.
